// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and constants shared by the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    localparam logic [31:0] ARB_ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating-priority arbiter sharing one req/ack memory between fetch and load/store.
// Defining ARB_TIMEOUT_EN adds a wait watchdog that aborts stuck accesses and pulses err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    arb_state_e        state, state_next;
    logic              last_d, last_d_next;
    logic              mem_req_next, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;
    logic [DATA_W-1:0] if_rdata_next, d_rdata_next;
    logic              if_valid_next, d_valid_next;
    logic              finish;
    logic [DATA_W-1:0] resp_word;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       err_next;
`endif

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_next     = state;
        last_d_next    = last_d;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        if_rdata_next  = if_rdata;
        d_rdata_next   = d_rdata;
        if_valid_next  = 1'b0;
        d_valid_next   = 1'b0;
        finish         = 1'b0;
        resp_word      = mem_rdata;
`ifdef ARB_TIMEOUT_EN
        wait_cnt_next  = wait_cnt;
        err_next       = 1'b0;
`endif

        unique case (state)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                wait_cnt_next = '0;
`endif
                // With both pending, last_d picks the side that did not win last time.
                if (d_req && !(if_req && last_d)) begin
                    state_next     = GRANT_D;
                    last_d_next    = 1'b1;
                    mem_req_next   = 1'b1;
                    mem_we_next    = d_we;
                    mem_addr_next  = d_addr;
                    mem_wdata_next = d_wdata;
                end else if (if_req) begin
                    state_next     = GRANT_I;
                    last_d_next    = 1'b0;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = if_addr;
                    mem_wdata_next = '0;
                end
            end

            GRANT_I, GRANT_D: begin
                finish = mem_ack;
`ifdef ARB_TIMEOUT_EN
                if (!mem_ack) begin
                    if (wait_cnt == TIMEOUT_CNT - 8'd1) begin
                        finish    = 1'b1;
                        resp_word = DATA_W'(ARB_ERR_WORD);
                        err_next  = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt + 8'd1;
                    end
                end
`endif
                if (finish) begin
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    if (state == GRANT_I) begin
                        if_valid_next = 1'b1;
                        if_rdata_next = resp_word;
                    end else begin
                        d_valid_next = 1'b1;
                        if (!mem_we) begin
                            d_rdata_next = resp_word;
                        end
                    end
                end
            end

            RESP: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            state     <= state_next;
            last_d    <= last_d_next;
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            if_rdata  <= if_rdata_next;
            d_rdata   <= d_rdata_next;
            if_valid  <= if_valid_next;
            d_valid   <= d_valid_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            err      <= err_next;
        end
    end
`endif

endmodule
